world_editor: RTL and testbench
===============================

Name: world_editor

Overview:
- Sits directly downstream of the world drawer; consumes its `looked_at_cube` / `looked_at_normal` result.
- On a user break or place request, edits the world cube memory, which the drawer reads every frame.
- Break clears the looked-at entry. Place scans the world, checks the adjacent cell is free, and writes a new cube into the first free slot.
- Writes occur only while the drawer is idle, so a frame never sees a half-applied edit.

Parameters:
- COORD_WIDTH, 32, drawer coordinate width; each world entry field is COORD_WIDTH/2 bits (integer part).
- WORLD_SIZE, 100, number of world memory entries.
- WORLD_BITS, 7, address width; all-ones means "no cube".
- NORMAL_WIDTH, 2, signed width of each normal component.
- READ_LATENCY, 2, world memory read latency in cycles (address to data).
- CUBE_STEP, 1, world-unit offset applied along the normal on place.
- WORLD_EXTENT, 64, only used with WORLD_EDIT_BOUNDS_EN.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset: synchronous, active-low.
- place  in  1  one-cycle place request
- break_req  in  1  one-cycle break request
- frame_busy  in  1  high while the drawer is traversing the world
- looked_at_cube  in  WORLD_BITS  drawer's center cube index; all-ones = none
- looked_at_normal  in  3*NORMAL_WIDTH  packed signed: [2]=x, [1]=y, [0]=z
- mem_rd_addr  out  WORLD_BITS  world read address
- mem_rd_data  in  3*COORD_WIDTH/2+1  {valid, x, y, z}
- mem_we  out  1  world write enable
- mem_wr_addr  out  WORLD_BITS  world write address
- mem_wr_data  out  3*COORD_WIDTH/2+1  entry to write
- busy  out  1  high from request accept until done
- done  out  1  one-cycle completion pulse
- status  out  3  0 OK, 1 NO_TARGET, 2 BAD_NORMAL, 3 OCCUPIED, 4 FULL, 5 OUT_OF_BOUNDS

Behaviour:
- Reset (rst_in==0 at clk edge):
  - Outputs: busy=0, done=0, mem_we=0, status=0, mem_rd_addr=0, mem_wr_addr=0, mem_wr_data=0.
  - State returns to IDLE; any in-progress edit is abandoned with no write.
- States: IDLE, PEND, RD_TGT, SCAN, WRITE, FIN.
- IDLE:
  - On place or break_req: latch op, looked_at_cube and looked_at_normal; busy<=1; go to PEND.
  - If both requests arrive in the same cycle, break wins.
  - Requests while busy=1 are dropped.
- PEND: waits while frame_busy=1; proceeds on the first cycle frame_busy=0.
  - Index all-ones: status<=NO_TARGET, go to FIN.
  - Break: go to WRITE with addr=index, data=0.
  - Place: go to RD_TGT.
- RD_TGT:
  - Drive mem_rd_addr=index and wait exactly READ_LATENCY cycles before sampling.
  - Target entry valid=0: NO_TARGET.
  - Normal must have exactly one nonzero component, with value +1 or -1; otherwise BAD_NORMAL.
  - New coordinate = target field + normal_component*CUBE_STEP, computed per axis in COORD_WIDTH/2-bit two's complement, wrapping.
- SCAN:
  - Addresses 0..WORLD_SIZE-1, one outstanding read at a time, READ_LATENCY wait per entry.
  - Valid entry equal to new coordinate: status<=OCCUPIED, go to FIN immediately.
  - First invalid entry: record as free slot; later invalid entries are ignored.
  - After the last address: free slot found goes to WRITE with {1,x,y,z}; none found gives FULL.
- WRITE: mem_we=1 for exactly one cycle; status<=OK; go to FIN.
- FIN: done=1 for one cycle, busy<=0, return to IDLE. status holds until the next request is accepted.
- mem_we is never asserted while frame_busy=1.
  - If frame_busy rises during RD_TGT or SCAN, the scan continues (reads only).
  - WRITE stalls until frame_busy=0.
- Worst-case place latency ≈ (WORLD_SIZE+1)*(READ_LATENCY+1)+4 cycles.

Optional Feature:
- Macro: WORLD_EDIT_BOUNDS_EN.
- Defined: place is rejected with status OUT_OF_BOUNDS (no scan, no write) if any new coordinate, read as signed, is <0 or >=WORLD_EXTENT. The check is made after RD_TGT.
- Undefined: no bounds check; wrapped coordinates are accepted, and status 5 never occurs.

Test Plan:
- Break: entry 5={1,3,4,0}, looked_at_cube=5, break_req pulse, frame_busy=0 -> one mem_we with addr 5, data 0; done pulse; status=0.
- Place OK:
  - Setup: entry 5 valid at (3,4,0); normal=(0,+1,0); entries 0-4 valid with other coords; entry 6 invalid.
  - Response: single write addr 6, data {1,3,5,0}; status=0.
- Occupied: same setup, but entry 9 valid at (3,5,0) -> no write; status=3.
- Errors:
  - looked_at_cube=127 -> status=1, no reads of the scan range.
  - normal=(1,1,0) -> status=2.
  - All 100 entries valid -> status=4.
- Interlock: frame_busy held high 50 cycles after a break request -> mem_we stays 0 until frame_busy falls, then exactly one write. A second request during busy is ignored.
- Reset mid-SCAN: rst_in=0 for one cycle -> busy=0, no write ever issued; next request runs normally.

Source files
------------

// File: rtl/world_editor.sv
// world_editor: applies break/place edits to the world cube memory, writing only between drawer frames.
// Optional macro WORLD_EDIT_BOUNDS_EN rejects placements outside [0, WORLD_EXTENT) on any axis.
module world_editor #(
  parameter int COORD_WIDTH  = 32,
  parameter int WORLD_SIZE   = 100,
  parameter int WORLD_BITS   = 7,
  parameter int NORMAL_WIDTH = 2,
  parameter int READ_LATENCY = 2,
  parameter int CUBE_STEP    = 1,
  parameter int WORLD_EXTENT = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      place,
  input  logic                      break_req,
  input  logic                      frame_busy,
  input  logic [WORLD_BITS-1:0]     looked_at_cube,
  input  logic [3*NORMAL_WIDTH-1:0] looked_at_normal,
  output logic [WORLD_BITS-1:0]     mem_rd_addr,
  input  logic [3*COORD_WIDTH/2:0]  mem_rd_data,
  output logic                      mem_we,
  output logic [WORLD_BITS-1:0]     mem_wr_addr,
  output logic [3*COORD_WIDTH/2:0]  mem_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                status,
  output logic [2:0]                dbg_state
);
  localparam int HW = COORD_WIDTH / 2;
  localparam int EW = 3 * HW + 1;
  localparam int NW = NORMAL_WIDTH;

  localparam logic [2:0] ST_OK         = 3'd0;
  localparam logic [2:0] ST_NO_TARGET  = 3'd1;
  localparam logic [2:0] ST_BAD_NORMAL = 3'd2;
  localparam logic [2:0] ST_OCCUPIED   = 3'd3;
  localparam logic [2:0] ST_FULL       = 3'd4;
  localparam logic [2:0] ST_OOB        = 3'd5;

  typedef enum logic [2:0] {IDLE, PEND, RD_TGT, SCAN, WRITE, FIN} state_t;

  // Request handshake: place/break_req are taken only in a cycle with busy=0 (others are dropped);
  // busy stays high until the single-cycle done pulse, which coincides with busy falling.
  state_t              state;
  logic                op_break;
  logic [WORLD_BITS-1:0] idx;
  logic [WORLD_BITS-1:0] free_slot;
  logic                free_found;
  logic [3*NW-1:0]     nrm;
  logic [7:0]          lat_cnt;
  logic [HW-1:0]       new_x, new_y, new_z;

  logic                rd_valid;
  logic [HW-1:0]       rd_x, rd_y, rd_z;
  logic signed [NW-1:0] n_x, n_y, n_z;
  logic [HW-1:0]       calc_x, calc_y, calc_z;
  logic                normal_ok, lat_done, entry_hit, last_addr, out_of_bounds;

  function automatic logic is_unit(input logic [NW-1:0] c);
    return (c == NW'(1)) || (c == {NW{1'b1}});
  endfunction

  function automatic logic coord_oob(input logic [HW-1:0] c);
    return c[HW-1] || (c >= HW'(WORLD_EXTENT));
  endfunction

  always_comb begin
    rd_valid  = mem_rd_data[EW-1];
    rd_x      = mem_rd_data[3*HW-1:2*HW];
    rd_y      = mem_rd_data[2*HW-1:HW];
    rd_z      = mem_rd_data[HW-1:0];
    n_x       = nrm[3*NW-1:2*NW];
    n_y       = nrm[2*NW-1:NW];
    n_z       = nrm[NW-1:0];
    // Exactly one axis carries +/-1, the other two are zero.
    normal_ok = (is_unit(n_x) && (n_y == '0) && (n_z == '0)) ||
                ((n_x == '0) && is_unit(n_y) && (n_z == '0)) ||
                ((n_x == '0) && (n_y == '0) && is_unit(n_z));
    calc_x    = rd_x + HW'(n_x * CUBE_STEP);
    calc_y    = rd_y + HW'(n_y * CUBE_STEP);
    calc_z    = rd_z + HW'(n_z * CUBE_STEP);
    lat_done  = (lat_cnt == 8'(READ_LATENCY));
    entry_hit = rd_valid && (rd_x == new_x) && (rd_y == new_y) && (rd_z == new_z);
    last_addr = (mem_rd_addr == WORLD_BITS'(WORLD_SIZE - 1));
`ifdef WORLD_EDIT_BOUNDS_EN
    out_of_bounds = coord_oob(calc_x) || coord_oob(calc_y) || coord_oob(calc_z);
`else
    out_of_bounds = 1'b0;
`endif
  end

  assign dbg_state = state;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_we      <= 1'b0;
      status      <= ST_OK;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      op_break    <= 1'b0;
      idx         <= '0;
      nrm         <= '0;
      lat_cnt     <= '0;
      free_found  <= 1'b0;
      free_slot   <= '0;
      new_x       <= '0;
      new_y       <= '0;
      new_z       <= '0;
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: if (break_req || place) begin
          op_break <= break_req;
          idx      <= looked_at_cube;
          nrm      <= looked_at_normal;
          busy     <= 1'b1;
          status   <= ST_OK;
          state    <= PEND;
        end
        PEND: if (!frame_busy) begin
          if (&idx) begin
            status <= ST_NO_TARGET;
            state  <= FIN;
          end else if (op_break) begin
            mem_wr_addr <= idx;
            mem_wr_data <= '0;
            state       <= WRITE;
          end else begin
            mem_rd_addr <= idx;
            lat_cnt     <= '0;
            state       <= RD_TGT;
          end
        end
        RD_TGT: if (!lat_done) begin
          lat_cnt <= lat_cnt + 8'd1;
        end else if (!rd_valid) begin
          status <= ST_NO_TARGET;
          state  <= FIN;
        end else if (!normal_ok) begin
          status <= ST_BAD_NORMAL;
          state  <= FIN;
        end else if (out_of_bounds) begin
          status <= ST_OOB;
          state  <= FIN;
        end else begin
          new_x       <= calc_x;
          new_y       <= calc_y;
          new_z       <= calc_z;
          mem_rd_addr <= '0;
          lat_cnt     <= '0;
          free_found  <= 1'b0;
          state       <= SCAN;
        end
        SCAN: if (!lat_done) begin
          lat_cnt <= lat_cnt + 8'd1;
        end else if (entry_hit) begin
          status <= ST_OCCUPIED;
          state  <= FIN;
        end else if (last_addr) begin
          if (free_found || !rd_valid) begin
            mem_wr_addr <= free_found ? free_slot : mem_rd_addr;
            mem_wr_data <= {1'b1, new_x, new_y, new_z};
            state       <= WRITE;
          end else begin
            status <= ST_FULL;
            state  <= FIN;
          end
        end else begin
          if (!rd_valid && !free_found) begin
            free_found <= 1'b1;
            free_slot  <= mem_rd_addr;
          end
          mem_rd_addr <= mem_rd_addr + 1'b1;
          lat_cnt     <= '0;
        end
        // The write is held back until the drawer is idle.
        WRITE: if (!frame_busy) begin
          mem_we <= 1'b1;
          status <= ST_OK;
          state  <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_world_editor.sv
// Bench for world_editor: directed cases plus randomized edits against a behavioural world model.
module tb_world_editor;
  localparam int WORLD_SIZE = 100;
  localparam int CUBE_STEP  = 1;
  localparam int E          = 49;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          place, break_req, frame_busy;
  logic [6:0]    looked_at_cube;
  logic [5:0]    looked_at_normal;
  logic [6:0]    mem_rd_addr;
  logic [E-1:0]  mem_rd_data = '0;
  logic          mem_we;
  logic [6:0]    mem_wr_addr;
  logic [E-1:0]  mem_wr_data;
  logic          busy, done;
  logic [2:0]    status;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  world_editor dut (
    .clk_in(clk), .rst_in(rst_in), .place(place), .break_req(break_req),
    .frame_busy(frame_busy), .looked_at_cube(looked_at_cube),
    .looked_at_normal(looked_at_normal), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_we(mem_we), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .done(done), .status(status),
    .dbg_state(dbg_state)
  );

  // World memory: written only by the stimulus process; read through a two-stage pipeline.
  logic [E-1:0] mem [0:WORLD_SIZE-1];
  logic [E-1:0] rd_p1 = '0;
  int           wr_cnt = 0, we_fb_cnt = 0, rd_chg = 0;
  logic [6:0]   last_wa = '0, prev_ra = '0;
  logic [E-1:0] last_wd = '0;
  int           n_vec = 0, n_err = 0;

  function automatic logic [E-1:0] rd_word(input logic [6:0] a);
    return (int'(a) < WORLD_SIZE) ? mem[a] : '0;
  endfunction

  always @(posedge clk) begin
    rd_p1       <= rd_word(mem_rd_addr);
    mem_rd_data <= rd_p1;
    if (mem_we) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_wr_addr;
      last_wd <= mem_wr_data;
      if (frame_busy) we_fb_cnt <= we_fb_cnt + 1;
    end
    if (mem_rd_addr != prev_ra) rd_chg <= rd_chg + 1;
    prev_ra <= mem_rd_addr;
  end

  function automatic logic [E-1:0] mk(input bit v, input int x, input int y, input int z);
    return {v, 16'(x), 16'(y), 16'(z)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < WORLD_SIZE; i++) mem[i] = '0;
  endtask

  task automatic setup_place();
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = mk(1, 10 + i, 20, 1);
    mem[5] = mk(1, 3, 4, 0);
  endtask

  // Reference: what an edit should do to the current world, from the editing rules alone.
  task automatic model(input bit brk, input logic [6:0] idx, input logic [5:0] nrm,
                       output logic [2:0] st, output int nw,
                       output logic [6:0] wa, output logic [E-1:0] wd);
    int comp[3];
    int nc[3];
    int nz, free;
    bit bad;
    logic signed [1:0] c;
    logic [E-1:0] t, e;
    st = 3'd0; nw = 0; wa = '0; wd = '0;
    if (idx == 7'h7f) begin st = 3'd1; return; end
    if (brk) begin nw = 1; wa = idx; return; end
    t = rd_word(idx);
    if (!t[48]) begin st = 3'd1; return; end
    nz = 0; bad = 0;
    for (int i = 0; i < 3; i++) begin
      c = nrm[(2 - i) * 2 +: 2];
      comp[i] = c;
      if (comp[i] != 0) nz++;
      if (comp[i] != 0 && comp[i] != 1 && comp[i] != -1) bad = 1;
    end
    if (nz != 1 || bad) begin st = 3'd2; return; end
    nc[0] = (int'(t[47:32]) + comp[0] * CUBE_STEP) & 32'hffff;
    nc[1] = (int'(t[31:16]) + comp[1] * CUBE_STEP) & 32'hffff;
    nc[2] = (int'(t[15:0])  + comp[2] * CUBE_STEP) & 32'hffff;
`ifdef WORLD_EDIT_BOUNDS_EN
    for (int i = 0; i < 3; i++) if (nc[i] >= 64) begin st = 3'd5; return; end
`endif
    free = -1;
    for (int i = 0; i < WORLD_SIZE; i++) begin
      e = mem[i];
      if (e[48] && int'(e[47:32]) == nc[0] && int'(e[31:16]) == nc[1] && int'(e[15:0]) == nc[2]) begin
        st = 3'd3; return;
      end
      if (!e[48] && free < 0) free = i;
    end
    if (free < 0) st = 3'd4;
    else begin nw = 1; wa = 7'(free); wd = mk(1, nc[0], nc[1], nc[2]); end
  endtask

  // fb: cycles frame_busy is high from the request; mid: cycle a 20-cycle frame starts; intr: cycle of an extra place request.
  task automatic do_op(input string tag, input bit brk, input bit plc, input logic [6:0] idx,
                       input logic [5:0] nrm, input int fb, input int mid, input int intr);
    logic [2:0] est;
    int enw, w0, f0;
    logic [6:0] ewa;
    logic [E-1:0] ewd;
    bit seen;
    model(brk, idx, nrm, est, enw, ewa, ewd);
    w0 = wr_cnt; f0 = we_fb_cnt; seen = 0;
    @(negedge clk);
    break_req = brk; place = plc; looked_at_cube = idx; looked_at_normal = nrm;
    frame_busy = (fb > 0);
    for (int c = 1; c < 1500 && !seen; c++) begin
      @(negedge clk);
      if (c == 1 || c == intr + 1) begin break_req = 0; place = 0; end
      if (done) seen = 1;
      if (!seen && intr > 1 && c == intr) begin place = 1; looked_at_cube = 7'd0; end
      if (!seen && c == fb - 1) check({tag, "/held_no_write"}, 64'(wr_cnt - w0), 64'd0);
      frame_busy = !seen && ((c < fb) || (mid > 0 && c >= mid && c < mid + 20));
    end
    break_req = 0; place = 0; frame_busy = 0;
    check({tag, "/done"}, 64'(seen), 64'd1);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    check({tag, "/status"}, 64'(status), 64'(est));
    check({tag, "/writes"}, 64'(wr_cnt - w0), 64'(enw));
    if (enw == 1 && wr_cnt - w0 == 1) begin
      check({tag, "/wr_addr"}, 64'(last_wa), 64'(ewa));
      check({tag, "/wr_data"}, 64'(last_wd), 64'(ewd));
    end
    repeat (4) @(negedge clk);
    check({tag, "/we_in_frame"}, 64'(we_fb_cnt - f0), 64'd0);
    check({tag, "/quiet_after"}, 64'({busy, 32'(wr_cnt - w0)}), 64'(enw));
    if (wr_cnt - w0 == 1) mem[last_wa] = last_wd;
  endtask

  initial begin
    int w0, r0, a;
    logic [5:0] nrm;
    logic [6:0] idx;
    bit brk, plc;
    rst_in = 0; place = 0; break_req = 0; frame_busy = 0;
    looked_at_cube = '0; looked_at_normal = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/mem_we", 64'(mem_we), 64'd0);
    check("rst/status", 64'(status), 64'd0);
    check("rst/rd_addr", 64'(mem_rd_addr), 64'd0);
    check("rst/wr_addr", 64'(mem_wr_addr), 64'd0);
    check("rst/wr_data", 64'(mem_wr_data), 64'd0);
    rst_in = 1;
    @(negedge clk);

    clear_mem(); mem[5] = mk(1, 3, 4, 0);
    do_op("break", 1, 0, 7'd5, 6'b0, 0, 0, 0);
    check("break/mem5_cleared", 64'(mem[5]), 64'd0);

    setup_place();
    do_op("place_ok", 0, 1, 7'd5, 6'b00_01_00, 0, 0, 0);

    setup_place(); mem[9] = mk(1, 3, 5, 0);
    do_op("occupied", 0, 1, 7'd5, 6'b00_01_00, 0, 0, 0);

    setup_place();
    r0 = rd_chg;
    do_op("no_target", 0, 1, 7'h7f, 6'b00_01_00, 0, 0, 0);
    check("no_target/no_reads", 64'(rd_chg - r0), 64'd0);

    setup_place();
    do_op("bad_normal", 0, 1, 7'd5, 6'b01_01_00, 0, 0, 0);

    for (int i = 0; i < WORLD_SIZE; i++) mem[i] = mk(1, i, 50, 0);
    do_op("full", 0, 1, 7'd5, 6'b00_01_00, 0, 0, 0);

    setup_place();
    do_op("both_req", 1, 1, 7'd5, 6'b00_01_00, 0, 0, 0);

    setup_place();
    do_op("interlock", 1, 0, 7'd2, 6'b0, 50, 0, 10);

    setup_place();
    do_op("frame_mid_scan", 0, 1, 7'd5, 6'b00_01_00, 0, 30, 0);

    // Reset in the middle of the scan abandons the edit.
    setup_place();
    w0 = wr_cnt;
    @(negedge clk); place = 1; looked_at_cube = 7'd5; looked_at_normal = 6'b00_01_00;
    @(negedge clk); place = 0;
    repeat (40) @(negedge clk);
    rst_in = 0;
    @(negedge clk); rst_in = 1;
    check("rst_scan/busy", 64'(busy), 64'd0);
    repeat (400) @(negedge clk);
    check("rst_scan/no_write", 64'(wr_cnt - w0), 64'd0);
    check("rst_scan/idle", 64'({busy, done}), 64'd0);
    do_op("after_rst", 0, 1, 7'd5, 6'b00_01_00, 0, 0, 0);

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < WORLD_SIZE; i++)
        mem[i] = (it % 8 == 0 || $urandom_range(0, 3) != 0)
                 ? mk(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3)) : '0;
      idx = ($urandom_range(0, 9) == 0) ? 7'h7f : 7'($urandom_range(0, WORLD_SIZE - 1));
      if ($urandom_range(0, 4) != 0) begin
        a = $urandom_range(0, 2);
        nrm = '0;
        nrm[a * 2 +: 2] = $urandom_range(0, 1) ? 2'b01 : 2'b11;
      end else nrm = 6'($urandom_range(0, 63));
      brk = ($urandom_range(0, 2) == 0);
      plc = !brk || ($urandom_range(0, 1) == 1);
      do_op("rand", brk, plc, idx, nrm,
            ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : 0,
            ($urandom_range(0, 2) == 0) ? $urandom_range(2, 200) : 0,
            ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
